// File: rtl/alu_seq.sv
// Sequential ALU feeding the CPU accumulator: one op per start, result plus a load strobe.
// Optional iterative multiplier on op 110 when ALU_MUL_EN is defined; otherwise op 110 is LOAD b.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             acc_we,
    output logic             zf,
    output logic             cf
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
`ifdef ALU_MUL_EN
        , ST_MUL = 2'd2
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zf_q, zf_d;
    logic             cf_q, cf_d;
    logic             acc_we_q, acc_we_d;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     mul_sum;
`endif

    logic             fin;
    logic [WIDTH-1:0] fin_res;
    logic             fin_cf;
    logic [SW-1:0]    shamt;

    assign shamt = b[SW-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        result_d = result_q;
        zf_d     = zf_q;
        cf_d     = cf_q;
        acc_we_d = 1'b0;
        fin      = 1'b0;
        fin_res  = '0;
        fin_cf   = 1'b0;
`ifdef ALU_MUL_EN
        prod_d   = prod_q;
        mul_sum  = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        3'b000: begin
                            {fin_cf, fin_res} = {1'b0, a} + {1'b0, b};
                            fin = 1'b1;
                        end
                        3'b001: begin
                            {fin_cf, fin_res} = {1'b0, a} - {1'b0, b};
                            fin = 1'b1;
                        end
                        3'b010: begin
                            fin_res = a & b;
                            fin     = 1'b1;
                        end
                        3'b011: begin
                            fin_res = a | b;
                            fin     = 1'b1;
                        end
                        3'b100: begin
                            fin_res = a ^ b;
                            fin     = 1'b1;
                        end
                        3'b101: begin
                            fin_res = ~a;
                            fin     = 1'b1;
                        end
                        3'b110: begin
`ifdef ALU_MUL_EN
                            // Multiplier sits in the low half; partial sums build in the high half.
                            state_d = ST_MUL;
                            cnt_d   = CW'(WIDTH);
                            opa_d   = a;
                            prod_d  = {{WIDTH{1'b0}}, b};
`else
                            fin_res = b;
                            fin     = 1'b1;
`endif
                        end
                        default: begin
                            if (shamt == '0) begin
                                fin_res = a;
                                fin     = 1'b1;
                            end else begin
                                state_d = ST_SHIFT;
                                cnt_d   = {1'b0, shamt};
                                opa_d   = a;
                            end
                        end
                    endcase
                end
            end

            ST_SHIFT: begin
                opa_d = {opa_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    fin     = 1'b1;
                    fin_res = {opa_q[WIDTH-2:0], 1'b0};
                    fin_cf  = opa_q[WIDTH-1];
                    state_d = ST_IDLE;
                end
            end

`ifdef ALU_MUL_EN
            ST_MUL: begin
                mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opa_q} : '0);
                prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    fin     = 1'b1;
                    fin_res = prod_d[WIDTH-1:0];
                    fin_cf  = |prod_d[2*WIDTH-1:WIDTH];
                    state_d = ST_IDLE;
                end
            end
`endif

            default: state_d = ST_IDLE;
        endcase

        if (fin) begin
            result_d = fin_res;
            cf_d     = fin_cf;
            zf_d     = (fin_res == '0);
            acc_we_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            result_q <= '0;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
            acc_we_q <= 1'b0;
`ifdef ALU_MUL_EN
            prod_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            result_q <= result_d;
            zf_q     <= zf_d;
            cf_q     <= cf_d;
            acc_we_q <= acc_we_d;
`ifdef ALU_MUL_EN
            prod_q   <= prod_d;
`endif
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign result = result_q;
    assign acc_we = acc_we_q;
    assign zf     = zf_q;
    assign cf     = cf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: scoreboard of expected completions compared on each acc_we.
// Expectations for op 110 follow ALU_MUL_EN (multiply) or its absence (LOAD b).
module tb_alu_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic [W-1:0] result;
    logic         acc_we;
    logic         zf;
    logic         cf;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         z;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .result (result),
        .acc_we (acc_we),
        .zf     (zf),
        .cf     (cf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model built from plain integer arithmetic, independent of the iterative datapath.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                  output exp_t e, output int lat);
        logic [63:0] full;
        int          n;
        lat  = 0;
        e.c  = 1'b0;
        full = '0;
        case (o)
            3'd0: begin
                full = 64'(av) + 64'(bv);
                e.r  = full[W-1:0];
                e.c  = full[W];
            end
            3'd1: begin
                e.r = W'(av - bv);
                e.c = (av < bv);
            end
            3'd2: e.r = av & bv;
            3'd3: e.r = av | bv;
            3'd4: e.r = av ^ bv;
            3'd5: e.r = ~av;
            3'd6: begin
`ifdef ALU_MUL_EN
                full = 64'(av) * 64'(bv);
                e.r  = full[W-1:0];
                e.c  = ((full >> W) != 0);
                lat  = W;
`else
                e.r = bv;
`endif
            end
            default: begin
                n    = int'(bv) % W;
                full = 64'(av) << n;
                e.r  = full[W-1:0];
                e.c  = (n == 0) ? 1'b0 : full[W];
                lat  = n;
            end
        endcase
        e.z = (e.r == '0);
    endfunction

    always @(negedge clk) begin
        if (rst_n && acc_we) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_acc_we", 32'(acc_we), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("result", 32'(result), 32'(e.r));
                checkOutput("cf", 32'(cf), 32'(e.c));
                checkOutput("zf", 32'(zf), 32'(e.z));
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input bit poke);
        exp_t e;
        int   lat;
        int   cycles;
        model(o, av, bv, e, lat);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        cycles = 0;
        while (busy && cycles < 100) begin
            if (poke && cycles == 2) begin
                start = 1'b1;
                op    = 3'd0;
            end else begin
                start = 1'b0;
            end
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("busy_cycles", 32'(cycles), 32'(lat));
        checkOutput("acc_we_at_done", 32'(acc_we), 32'd1);
        @(negedge clk);
        checkOutput("acc_we_one_cycle", 32'(acc_we), 32'd0);
    endtask

    task automatic resetMidOp(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("busy_before_reset", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_acc_we", 32'(acc_we), 32'd0);
        checkOutput("rst_zf", 32'(zf), 32'd0);
        checkOutput("rst_cf", 32'(cf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   lat;
        rst_n = 1'b0;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_acc_we", 32'(acc_we), 32'd0);
        checkOutput("reset_zf", 32'(zf), 32'd0);
        checkOutput("reset_cf", 32'(cf), 32'd0);
        rst_n = 1'b1;

        applyStimulus(3'd0, 8'hF0, 8'h20, 1'b0);
        applyStimulus(3'd1, 8'h05, 8'h05, 1'b0);
        applyStimulus(3'd1, 8'h03, 8'h05, 1'b0);
        applyStimulus(3'd2, 8'hCC, 8'hAA, 1'b0);
        applyStimulus(3'd3, 8'hC0, 8'h0A, 1'b0);
        applyStimulus(3'd4, 8'h5A, 8'h5A, 1'b0);
        applyStimulus(3'd5, 8'h0F, 8'h00, 1'b0);
        applyStimulus(3'd6, 8'h12, 8'h10, 1'b1);
        applyStimulus(3'd6, 8'h12, 8'h34, 1'b0);
        applyStimulus(3'd6, 8'hFF, 8'hFF, 1'b0);
        applyStimulus(3'd7, 8'h81, 8'h01, 1'b0);
        applyStimulus(3'd7, 8'h81, 8'h03, 1'b1);
        applyStimulus(3'd7, 8'h81, 8'h00, 1'b0);
        applyStimulus(3'd7, 8'hFF, 8'h0F, 1'b0);

        // Three accepted starts on consecutive edges must give three strobes.
        @(negedge clk);
        start = 1'b1;
        op = 3'd0; a = 8'h11; b = 8'h22;
        model(op, a, b, e, lat);
        sb.push_back(e);
        @(negedge clk);
        op = 3'd4; a = 8'hF0; b = 8'h0F;
        model(op, a, b, e, lat);
        sb.push_back(e);
        @(negedge clk);
        op = 3'd1; a = 8'h00; b = 8'h01;
        model(op, a, b, e, lat);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("b2b_drained", 32'(sb.size()), 32'd0);

        resetMidOp(3'd7, 8'h81, 8'h07);
        applyStimulus(3'd0, 8'h01, 8'h01, 1'b0);
`ifdef ALU_MUL_EN
        resetMidOp(3'd6, 8'h12, 8'h10);
        applyStimulus(3'd0, 8'h01, 8'h01, 1'b0);
`endif

        for (int i = 0; i < 20; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential arithmetic/logic unit sitting directly upstream of the CPU accumulator register. Takes the current accumulator value and a memory/immediate operand, executes one operation per `start`, and delivers `result` plus a one-cycle `acc_we` strobe wired to the accumulator's data input and load enable. Simple ops complete in one cycle; multiply and multi-bit shift are iterative and hold `busy` while running.

## Interface
- `WIDTH`, default 8: datapath width. Only 8 and 16 are supported.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  operation request, sampled on the rising edge.
- `op`  in  3  opcode, sampled with `start`.
- `a`  in  WIDTH  accumulator operand, driven from the accumulator output.
- `b`  in  WIDTH  second operand.
- `busy`  out  1  multi-cycle operation in progress.
- `result`  out  WIDTH  registered result, drives the accumulator data input.
- `acc_we`  out  1  one-cycle load strobe, drives the accumulator enable.
- `zf`  out  1  zero flag: `result == 0`.
- `cf`  out  1  carry/borrow/shift-out flag.

## Operation
- **Opcodes**
  - 000 ADD: cf = carry out.
  - 001 SUB (a−b): cf = borrow, i.e. a<b unsigned.
  - 010 AND, 011 OR, 100 XOR: cf=0.
  - 101 NOT a: cf=0.
  - 110 MUL: result = low WIDTH bits of a×b unsigned; cf = OR of the high WIDTH bits.
  - 111 SHL: shift a left by `b[log2(WIDTH)-1:0]`; cf = last bit shifted out.
- **States:** IDLE, MUL, SHIFT.
- **Accepting a request:** `start` is accepted only on an edge where the state is IDLE. Operands and op are latched at acceptance, so later changes on `a`, `b` or `op` have no effect.
- **IDLE transitions**
  - Single-cycle ops, and SHL with count 0 (result=a, cf=0): compute, register `result`/`zf`/`cf`, pulse `acc_we`, stay in IDLE.
  - MUL: go to MUL with iteration counter = WIDTH.
  - SHL with count N>0: go to SHIFT with counter = N.
- **MUL:** shift-add, one multiplier bit per cycle into a 2·WIDTH product register. When the counter reaches its last iteration: register the outputs, pulse `acc_we`, return to IDLE.
- **SHIFT:** one bit per cycle. On the last bit: register the outputs, pulse `acc_we`, return to IDLE.
- **Output hold:** `result`, `zf` and `cf` hold until the next completion. `zf` always reflects the registered `result`.
- **`start` while busy:** ignored. It is neither queued nor an error.
- **Reset:** all outputs go to 0 and the state to IDLE, regardless of activity. A reset mid-operation aborts it, and no `acc_we` is produced for the aborted op.

## Timing
- Reset values: `busy`=0, `result`=0, `acc_we`=0, `zf`=0, `cf`=0.
- Accept edge k, single-cycle op: outputs update at edge k; `acc_we`=1 from k to k+1; `busy` stays 0.
- MUL: `busy`=1 from edge k to k+WIDTH. Iterations run at edges k+1..k+WIDTH. Outputs update and `acc_we` is high for the cycle after edge k+WIDTH. The earliest next accept is edge k+WIDTH+1.
- SHL, N>0: same as MUL with WIDTH replaced by N.
- `acc_we` is never high for two consecutive cycles from one op.
- Back-to-back single-cycle ops produce one `acc_we` per accepted `start`.

## Configuration
- `ALU_MUL_EN` defined: op 110 is the iterative multiplier described above.
- `ALU_MUL_EN` undefined:
  - The multiplier datapath and MUL state are removed.
  - Op 110 becomes LOAD: single-cycle, result=b, cf=0, `busy` never asserts.

## Test plan
- ADD a=0xF0, b=0x20 -> at the edge after `start`: result=0x10, cf=1, zf=0; `acc_we` high exactly one cycle.
- SUB a=0x05, b=0x05 -> result=0x00, zf=1, cf=0. Then SUB a=0x03, b=0x05 -> result=0xFE, cf=1, zf=0.
- MUL a=0x12, b=0x10 (`ALU_MUL_EN` defined) -> `busy` high 8 cycles; result=0x20, cf=1, `acc_we` after edge k+8. A `start` pulse (op=ADD) during `busy` produces no extra `acc_we`.
- SHL a=0x81, b=1 -> `busy` 1 cycle, result=0x02, cf=1. SHL a=0x81, b=3 -> `busy` 3 cycles, result=0x08, cf=0. SHL b=0 -> single cycle, result=0x81, cf=0.
- Assert `rst_n`=0 during the 4th MUL iteration -> all outputs 0 immediately; no `acc_we` after release; a following ADD 0x01+0x01 gives result=0x02 normally.
- `ALU_MUL_EN` undefined, op=110, a=0x12, b=0x34 -> result=0x34 at the next edge, cf=0, `busy` stays 0.
